// File: rtl/vending_arbiter_pkg.sv
// vending_arbiter_pkg: coin encoding, coin values and arbiter state shared by the vending front end.
package vending_arbiter_pkg;

    typedef enum logic [1:0] {NONE = 2'd0, NICKEL = 2'd1, DIME = 2'd2, QUARTER = 2'd3} coin_t;

    typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

    function automatic logic [4:0] coin_val(coin_t c);
        return (c == QUARTER) ? 5'd5 : {3'b000, c};
    endfunction

endpackage

// File: rtl/vending_arbiter_if.sv
// vending_arbiter_if: customer-side slots and vending-side coin/beverage signals of the arbiter.
interface vending_arbiter_if
    import vending_arbiter_pkg::*;
#(
    parameter int N_CUST   = 4,
    parameter int CNT_BITS = 8
);
    logic [N_CUST-1:0]          cust_coin_valid;
    logic [2*N_CUST-1:0]        cust_coin;
    logic [N_CUST-1:0]          cust_coin_ready;
    logic [N_CUST-1:0]          cust_grant;
    logic [2*N_CUST-1:0]        cust_change;
    logic [N_CUST-1:0]          cust_beverage;
    coin_t                      deposit;
    coin_t                      change;
    logic                       beverage;
    logic                       enable;
    logic [N_CUST*CNT_BITS-1:0] served_cnt;

    modport slave (
        input  cust_coin_valid, cust_coin, change, beverage, enable,
        output cust_coin_ready, cust_grant, cust_change, cust_beverage, deposit, served_cnt
    );

    modport master (
        output cust_coin_valid, cust_coin, change, beverage, enable,
        input  cust_coin_ready, cust_grant, cust_change, cust_beverage, deposit, served_cnt
    );
endinterface

// File: rtl/vending_arbiter_rr_picker.sv
// vending_arbiter_rr_picker: first requesting slot after ptr, wrapping modulo N_CUST.
module vending_arbiter_rr_picker #(
    parameter int N_CUST = 4,
    parameter int IW     = $clog2(N_CUST)
) (
    input  logic [N_CUST-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [N_CUST-1:0] pick,
    output logic [IW-1:0]     idx
);
    logic [IW-1:0] sel;

    // Scan from farthest to nearest so the nearest requester overwrites the rest.
    always_comb begin
        pick = '0;
        idx  = '0;
        sel  = '0;
        for (int k = N_CUST; k >= 1; k--) begin
            sel = IW'((int'(ptr) + k) % N_CUST);
            if (req[sel]) begin
                pick      = '0;
                pick[sel] = 1'b1;
                idx       = sel;
            end
        end
    end
endmodule

// File: rtl/vending_arbiter.sv
// vending_arbiter: round-robin share of one vending machine among N_CUST coin slots.
// Define VEND_STATS_EN to build the saturating per-slot served counters.
module vending_arbiter
    import vending_arbiter_pkg::*;
#(
    parameter int N_CUST   = 4,
    parameter int CNT_BITS = 8
) (
    input logic              clock,
    input logic              reset,
    vending_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_CUST);

    state_t            state, state_nx;
    logic [N_CUST-1:0] grant, grant_nx, pick;
    logic [IW-1:0]     rr_ptr, rr_ptr_nx, pick_idx;
    logic [4:0]        net, net_nx;
    logic              started, started_nx, xfer, done;
    coin_t             deposit, deposit_nx, sel_coin;

    vending_arbiter_rr_picker #(.N_CUST(N_CUST)) picker (
        .req  (bus.cust_coin_valid),
        .ptr  (rr_ptr),
        .pick (pick),
        .idx  (pick_idx)
    );

    always_comb begin
        sel_coin = NONE;
        for (int i = 0; i < N_CUST; i++)
            if (grant[i]) sel_coin = coin_t'(bus.cust_coin[2*i +: 2]);
    end

    assign xfer = (|(grant & bus.cust_coin_valid)) & bus.enable;
    // Refund/rejection is complete once every coin in flight has come back and nothing is moving.
    assign done = bus.beverage
                | (started & net == 5'd0 & bus.enable & deposit == NONE & bus.change == NONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            rr_ptr  <= IW'(N_CUST - 1);
            net     <= '0;
            started <= 1'b0;
            deposit <= NONE;
        end else begin
            state   <= state_nx;
            grant   <= grant_nx;
            rr_ptr  <= rr_ptr_nx;
            net     <= net_nx;
            started <= started_nx;
            deposit <= deposit_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        grant_nx   = grant;
        rr_ptr_nx  = rr_ptr;
        net_nx     = net;
        started_nx = started;
        deposit_nx = xfer ? sel_coin : NONE;
        if (state == IDLE) begin
            if (|bus.cust_coin_valid) begin
                state_nx  = GRANTED;
                grant_nx  = pick;
                rr_ptr_nx = pick_idx;
            end
        end else if (done) begin
            state_nx   = IDLE;
            grant_nx   = '0;
            net_nx     = '0;
            started_nx = 1'b0;
        end else begin
            net_nx     = net + (xfer ? coin_val(sel_coin) : 5'd0) - coin_val(bus.change);
            started_nx = started | xfer;
        end
    end

    assign bus.deposit         = deposit;
    assign bus.cust_grant      = grant;
    assign bus.cust_coin_ready = grant & {N_CUST{bus.enable}};
    assign bus.cust_beverage   = grant & {N_CUST{bus.beverage}};

    for (genvar g = 0; g < N_CUST; g++) begin : g_route
        assign bus.cust_change[2*g +: 2] = grant[g] ? bus.change : NONE;
    end

`ifdef VEND_STATS_EN
    for (genvar g = 0; g < N_CUST; g++) begin : g_cnt
        logic [CNT_BITS-1:0] cnt;
        always_ff @(posedge clock) begin
            if (reset) cnt <= '0;
            else if (bus.beverage & grant[g] & ~&cnt) cnt <= cnt + 1'b1;
        end
        assign bus.served_cnt[g*CNT_BITS +: CNT_BITS] = cnt;
    end
`else
    assign bus.served_cnt = '0;
`endif
endmodule
